// File: rtl/range_stream_sequencer.sv
//------------------------------------------------------------------------------
// Module      : range_stream_sequencer
// Description : Buffers a burst of sample words and replays it with go/finish
//               framing for the range-finder input interface.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module range_stream_sequencer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ZERO  = CW'(0);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_TWO   = CW'(2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND_GO  = 2'd1,
        S_STREAM   = 2'd2,
        S_SEND_FIN = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_done;
    logic             r_err;
    logic             w_push;
    logic             w_pop;
    logic             w_start_ok;
    logic             w_start_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A write in the same cycle as start counts toward the burst, so an empty
    // buffer plus a write plus start launches a one-word burst without err.
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_start_ok    = 1'b0;
        w_start_empty = 1'b0;
        go            = 1'b0;
        finish        = 1'b0;
        busy          = 1'b1;
        w_push        = (r_state == S_IDLE) && wr_valid && (r_count != C_DEPTH);
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_push || (r_count != C_ZERO)) begin
                        w_start_ok   = 1'b1;
                        w_next_state = S_SEND_GO;
                    end else begin
                        w_start_empty = 1'b1;
                    end
                end
            end
            S_SEND_GO: begin
                go = 1'b1;
                // A lone word is held and re-sent with finish; go&finish together is illegal downstream.
                if (r_count == C_ONE) begin
                    w_next_state = S_SEND_FIN;
                end else begin
                    w_pop = 1'b1;
                    if (r_count == C_TWO) begin
                        w_next_state = S_SEND_FIN;
                    end else begin
                        w_next_state = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                w_pop = 1'b1;
                if (r_count == C_TWO) begin
                    w_next_state = S_SEND_FIN;
                end
            end
            S_SEND_FIN: begin
                finish       = 1'b1;
                w_pop        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pushes only happen in IDLE and pops only in send states, so they never overlap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end else if (w_pop && (r_count != C_ZERO)) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state == S_SEND_FIN);
            if (w_start_empty) begin
                r_err <= 1'b1;
            end else if (w_start_ok) begin
                r_err <= 1'b0;
            end
        end
    end

    assign wr_ready = (r_state == S_IDLE) && (r_count != C_DEPTH);
    assign data_out = (r_state == S_IDLE) ? '0 : r_mem[r_rd_ptr];
    assign done     = r_done;
    assign err      = r_err;
    assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_range_stream_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_range_stream_sequencer
// Description : Randomized self-checking bench against a queue-based burst model.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_range_stream_sequencer;

    localparam int WIDTH = 10;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic             done;
    logic             err;
    logic [CW-1:0]    count;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] m_q[$];
    logic             m_err = 1'b0;

    range_stream_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .start    (start),
        .data_out (data_out),
        .go       (go),
        .finish   (finish),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(busy),     32'(0));
        check({tag, "_go"},     32'(go),       32'(0));
        check({tag, "_finish"}, 32'(finish),   32'(0));
        check({tag, "_data"},   32'(data_out), 32'(0));
        check({tag, "_count"},  32'(count),    32'(m_q.size()));
        check({tag, "_err"},    32'(err),      32'(m_err));
        check({tag, "_ready"},  32'(wr_ready), 32'(m_q.size() < DEPTH));
    endtask

    task automatic write_word(input logic [WIDTH-1:0] w);
        check("wr_ready_pre", 32'(wr_ready), 32'(m_q.size() < DEPTH));
        wr_valid = 1'b1;
        wr_data  = w;
        tick();
        wr_valid = 1'b0;
        if (m_q.size() < DEPTH) m_q.push_back(w);
        check_idle("write");
    endtask

    // Start a burst and check every wire cycle against the framing rules.
    task automatic do_start(input bit with_write, input logic [WIDTH-1:0] w, input bit poke);
        logic [WIDTH-1:0] exp_q[$];
        int n;
        int len;
        start = 1'b1;
        if (with_write) begin
            wr_valid = 1'b1;
            wr_data  = w;
        end
        tick();
        start    = 1'b0;
        wr_valid = 1'b0;
        if (with_write && m_q.size() < DEPTH) m_q.push_back(w);
        if (m_q.size() == 0) begin
            m_err = 1'b1;
            check_idle("empty_start");
            check("empty_start_done", 32'(done), 32'(0));
            return;
        end
        m_err = 1'b0;
        exp_q = m_q;
        m_q.delete();
        n   = exp_q.size();
        len = (n == 1) ? 2 : n;
        for (int k = 0; k < len; k++) begin
            check("burst_go",     32'(go),       32'(k == 0));
            check("burst_finish", 32'(finish),   32'(k == len - 1));
            check("burst_data",   32'(data_out), 32'(exp_q[(n == 1) ? 0 : k]));
            check("burst_busy",   32'(busy),     32'(1));
            check("burst_count",  32'(count),    32'((n == 1) ? 1 : n - k));
            check("burst_err",    32'(err),      32'(0));
            check("burst_ready",  32'(wr_ready), 32'(0));
            check("burst_done",   32'(done),     32'(0));
            if (poke) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_data  = WIDTH'($urandom);
                start    = 1'($urandom_range(0, 1));
            end
            tick();
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        check("done_pulse", 32'(done), 32'(1));
        check_idle("post_burst");
        tick();
        check("done_clear", 32'(done), 32'(0));
    endtask

    initial begin
        int nw;
        #2;
        check("rst_go",     32'(go),       32'(0));
        check("rst_finish", 32'(finish),   32'(0));
        check("rst_busy",   32'(busy),     32'(0));
        check("rst_done",   32'(done),     32'(0));
        check("rst_err",    32'(err),      32'(0));
        check("rst_count",  32'(count),    32'(0));
        check("rst_data",   32'(data_out), 32'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_idle("after_rst");

        // Four-word burst
        write_word(10'd5); write_word(10'd9); write_word(10'd2); write_word(10'd7);
        do_start(1'b0, '0, 1'b0);
        // Single word
        write_word(10'd3);
        do_start(1'b0, '0, 1'b0);
        // Empty start sets err, next good start clears it
        do_start(1'b0, '0, 1'b0);
        write_word(10'd1);
        do_start(1'b0, '0, 1'b0);
        // Fill, overflow attempt, wrap
        for (int i = 10; i <= 17; i++) write_word(WIDTH'(i));
        write_word(10'd18);
        do_start(1'b0, '0, 1'b0);
        write_word(10'd20); write_word(10'd21); write_word(10'd22);
        do_start(1'b0, '0, 1'b0);

        // Reset in the middle of a six-word burst
        for (int i = 0; i < 6; i++) write_word(WIDTH'(100 + i));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("mid_rst_go",     32'(go),     32'(0));
        check("mid_rst_finish", 32'(finish), 32'(0));
        check("mid_rst_busy",   32'(busy),   32'(0));
        check("mid_rst_count",  32'(count),  32'(0));
        check("mid_rst_err",    32'(err),    32'(0));
        m_q.delete();
        m_err = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_idle("post_mid_rst");

        // Write and start together on an empty buffer
        do_start(1'b1, 10'd4, 1'b0);
        // Ignored pokes during a burst
        write_word(10'd33); write_word(10'd44); write_word(10'd55);
        do_start(1'b0, '0, 1'b1);

        // Randomized bursts
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, DEPTH + 2);
            for (int j = 0; j < nw; j++) write_word(WIDTH'($urandom));
            do_start(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
